// File: rtl/shift_pipe_gen_if.sv
// ---------------------------------------------------------------------------
// shift_pipe_gen_if
//   Streaming bus for the pipelined barrel shifter. The producer side carries
//   a word, a shift amount and a mode under valid/ready. The consumer side
//   carries the shifted result under valid/ready.
//
//   Parameters:
//     width   data width in bits (shift amount is clog2(width) bits)
//
//   Signals:
//     iValid  producer -> shifter   input word valid
//     iReady  shifter  -> producer  shifter accepts the input this cycle
//     iBits   producer -> shifter   input word
//     iShift  producer -> shifter   shift amount
//     iMode   producer -> shifter   0 lsl, 1 lsr, 2 asr, 3 rotate left
//     oValid  shifter  -> consumer  result valid
//     oReady  consumer -> shifter   consumer accepts the result this cycle
//     oBits   shifter  -> consumer  shifted result
//
//   Modports:
//     master  the environment driving the shifter (producer + consumer)
//     slave   the shifter itself
// ---------------------------------------------------------------------------
interface shift_pipe_gen_if #(
  parameter int width = 8
) ();

  localparam int S = $clog2(width);

  logic             iValid;
  logic             iReady;
  logic [width-1:0] iBits;
  logic [S-1:0]     iShift;
  logic [1:0]       iMode;
  logic             oValid;
  logic             oReady;
  logic [width-1:0] oBits;

  modport master (
    output iValid, iBits, iShift, iMode, oReady,
    input  iReady, oValid, oBits
  );

  modport slave (
    input  iValid, iBits, iShift, iMode, oReady,
    output iReady, oValid, oBits
  );

endinterface

// File: rtl/shift_pipe_gen.sv
// ---------------------------------------------------------------------------
// shift_pipe_gen
//   Pipelined left/right barrel shifter with valid/ready flow control.
//   The shift amount is applied as a chain of power-of-two sub-shifts
//   (bit k of the amount shifts by 2^k). The chain is cut into `stages`
//   register stages, each handling a contiguous group of amount bits,
//   low bits first. Stages with no amount bits left are plain registers.
//
//   Parameters:
//     width   data width, >= 2, any value (not only powers of two)
//     stages  register stages, 1 .. clog2(width)
//
//   Ports:
//     clk     rising-edge clock
//     rst     synchronous active-high reset, clears valids and data
//     bus     shift_pipe_gen_if.slave (input word/amount/mode handshake
//             and output result handshake)
//
//   Configuration macro:
//     SHIFT_PIPE_GEN_ROTATE_EN  when defined, mode 3 rotates left; when not
//                               defined the rotate datapath is absent and
//                               mode 3 is a logical left shift.
// ---------------------------------------------------------------------------
module shift_pipe_gen #(
  parameter int width  = 8,
  parameter int stages = 1
) (
  input  logic            clk,
  input  logic            rst,
  shift_pipe_gen_if.slave bus
);

  localparam int S = $clog2(width);
  // Amount bits handled per stage, rounded up so every bit has a home.
  localparam int B = (S + stages - 1) / stages;

  logic [stages:0]              rdy;
  logic [stages-1:0]            v_q;
  logic [stages-1:0][width-1:0] d_q;
  logic [stages-1:0][S-1:0]     sh_q;
  logic [stages-1:0][1:0]       md_q;

  // One power-of-two step of the shift network. Because 2^k < width for
  // every amount bit, each step is well defined; amounts >= width fall out
  // of the composition (zeros, sign fill, or a wrapped rotate).
  function automatic logic [width-1:0] sub_shift(
    input logic [width-1:0] d,
    input logic [1:0]       md,
    input int               k
  );
    int                      n;
    logic signed [width-1:0] sd;
    logic [width-1:0]        r;
    n  = 1 << k;
    sd = d;
    case (md)
      2'd1:    r = d >> n;
      2'd2:    r = sd >>> n;
`ifdef SHIFT_PIPE_GEN_ROTATE_EN
      2'd3:    r = (d << n) | (d >> (width - n));
`else
      2'd3:    r = d << n;
`endif
      default: r = d << n;
    endcase
    return r;
  endfunction

  // Backpressure chain: a stage can take a new word when it is empty or
  // when the stage after it is moving on this cycle.
  assign rdy[stages] = bus.oReady;
  assign bus.iReady  = rdy[0] && !rst;
  assign bus.oValid  = v_q[stages-1];
  assign bus.oBits   = d_q[stages-1];

  for (genvar j = 0; j < stages; j++) begin : g_stage
    localparam int LO = j * B;
    localparam int HI = ((((j + 1) * B) < S) ? ((j + 1) * B) : S) - 1;

    logic             up_v;
    logic [width-1:0] up_d;
    logic [S-1:0]     up_sh;
    logic [1:0]       up_md;
    logic [width-1:0] nxt_d;

    logic             v_r;
    logic [width-1:0] d_r;
    logic [S-1:0]     sh_r;
    logic [1:0]       md_r;

    if (j == 0) begin : g_src
      assign up_v  = bus.iValid;
      assign up_d  = bus.iBits;
      assign up_sh = bus.iShift;
      assign up_md = bus.iMode;
    end else begin : g_src
      assign up_v  = v_q[j-1];
      assign up_d  = d_q[j-1];
      assign up_sh = sh_q[j-1];
      assign up_md = md_q[j-1];
    end

    assign rdy[j] = !v_q[j] || rdy[j+1];

    // Apply only this stage's group of amount bits; an empty group
    // (LO > HI) leaves the word untouched.
    always_comb begin
      nxt_d = up_d;
      for (int k = 0; k < S; k++) begin
        if ((k >= LO) && (k <= HI) && up_sh[k]) begin
          nxt_d = sub_shift(nxt_d, up_md, k);
        end
      end
    end

    // Stage register: the shift amount and mode travel with the word so
    // later stages can apply the remaining amount bits.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_r  <= 1'b0;
        d_r  <= '0;
        sh_r <= '0;
        md_r <= '0;
      end else if (rdy[j]) begin
        v_r  <= up_v;
        d_r  <= nxt_d;
        sh_r <= up_sh;
        md_r <= up_md;
      end
    end

    assign v_q[j]  = v_r;
    assign d_q[j]  = d_r;
    assign sh_q[j] = sh_r;
    assign md_q[j] = md_r;
  end

  // The last stage's amount and mode have no consumer.
  logic unused_ctx;
  assign unused_ctx = ^{sh_q[stages-1], md_q[stages-1]};

endmodule

// File: tb/tb_shift_pipe_gen.sv
// ---------------------------------------------------------------------------
// tb_shift_pipe_gen
//   Directed and random checks of shift_pipe_gen in three configurations:
//     dutA  width 8, stages 3
//     dutB  width 6, stages 2
//     dutC  width 8, stages 1
//   Inputs are driven on the falling edge, outputs sampled 1 time unit
//   later. Expected values come from hand-computed constants and from a
//   direct-formula reference model.
//   Honours SHIFT_PIPE_GEN_ROTATE_EN for the mode 3 expectations.
// ---------------------------------------------------------------------------
module tb_shift_pipe_gen;

`ifdef SHIFT_PIPE_GEN_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] qc[$];

  always #5 clk = ~clk;

  shift_pipe_gen_if #(.width(8)) a ();
  shift_pipe_gen_if #(.width(6)) b ();
  shift_pipe_gen_if #(.width(8)) c ();

  shift_pipe_gen #(.width(8), .stages(3)) dutA (.clk(clk), .rst(rst), .bus(a.slave));
  shift_pipe_gen #(.width(6), .stages(2)) dutB (.clk(clk), .rst(rst), .bus(b.slave));
  shift_pipe_gen #(.width(8), .stages(1)) dutC (.clk(clk), .rst(rst), .bus(c.slave));

  // Reference result computed directly from the amount, not by composition.
  function automatic logic [15:0] model(input logic [15:0] d, input int s,
                                        input logic [1:0] md, input int w);
    logic [15:0] mask;
    logic [15:0] r;
    logic        sign;
    int          amt;
    mask = (16'd1 << w) - 16'd1;
    sign = d[w-1];
    r    = 16'd0;
    if (md == 2'd3 && !ROT) md = 2'd0;
    case (md)
      2'd0: r = (s >= w) ? 16'd0 : (d << s);
      2'd1: r = (s >= w) ? 16'd0 : (d >> s);
      2'd2: r = (s >= w) ? (sign ? mask : 16'd0)
                         : ((d >> s) | (sign ? (mask & ~(mask >> s)) : 16'd0));
      default: begin
        amt = s % w;
        r = (amt == 0) ? d : ((d << amt) | (d >> (w - amt)));
      end
    endcase
    return r & mask;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d,
                               input logic [2:0] s, input logic [1:0] m);
    a.iValid = v;
    a.iBits  = d;
    a.iShift = s;
    a.iMode  = m;
  endtask

  // Scoreboard step for all three DUTs at the current sample point.
  task automatic monitorCycle();
    logic [15:0] exp;
    if (a.oValid && a.oReady) begin
      exp = (qa.size() != 0) ? qa.pop_front() : 16'hFFFF;
      checkOutput("rnd_s3", 16'(a.oBits), exp);
    end
    if (a.iValid && a.iReady) qa.push_back(model(16'(a.iBits), int'(a.iShift), a.iMode, 8));
    if (b.oValid && b.oReady) begin
      exp = (qb.size() != 0) ? qb.pop_front() : 16'hFFFF;
      checkOutput("rnd_s2", 16'(b.oBits), exp);
    end
    if (b.iValid && b.iReady) qb.push_back(model(16'(b.iBits), int'(b.iShift), b.iMode, 6));
    if (c.oValid && c.oReady) begin
      exp = (qc.size() != 0) ? qc.pop_front() : 16'hFFFF;
      checkOutput("rnd_s1", 16'(c.oBits), exp);
    end
    if (c.iValid && c.iReady) qc.push_back(model(16'(c.iBits), int'(c.iShift), c.iMode, 8));
  endtask

  initial begin
    logic [7:0] bp [5];
    logic [7:0] bpExp [5];
    int acc;
    int got;
    int stale;

    bp    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bpExp = '{8'h22, 8'h44, 8'h66, 8'h88, 8'hAA};

    applyStimulus(1'b0, 8'h00, 3'd0, 2'd0);
    a.oReady = 1'b1;
    b.iValid = 1'b0; b.iBits = 6'h00; b.iShift = 3'd0; b.iMode = 2'd0; b.oReady = 1'b1;
    c.iValid = 1'b0; c.iBits = 8'h00; c.iShift = 3'd0; c.iMode = 2'd0; c.oReady = 1'b1;

    // Reset state
    @(negedge clk); #1;
    checkOutput("rst_iready_forced", 16'(a.iReady), 16'd0);
    @(negedge clk); #1;
    checkOutput("rst_ovalid", 16'(a.oValid), 16'd0);
    checkOutput("rst_obits", 16'(a.oBits), 16'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_iready", 16'(a.iReady), 16'd1);

    // Single word, latency of 3 on dutA
    @(negedge clk);
    applyStimulus(1'b1, 8'hB4, 3'd3, 2'd0);
    #1 checkOutput("t1_iready", 16'(a.iReady), 16'd1);
    @(negedge clk);
    a.iValid = 1'b0;
    #1 checkOutput("t1_lat1_ovalid", 16'(a.oValid), 16'd0);
    @(negedge clk); #1;
    checkOutput("t1_lat2_ovalid", 16'(a.oValid), 16'd0);
    @(negedge clk); #1;
    checkOutput("t1_lat3_ovalid", 16'(a.oValid), 16'd1);
    checkOutput("t1_lsl3", 16'(a.oBits), 16'h00A0);
    @(negedge clk); #1;
    checkOutput("t1_after_ovalid", 16'(a.oValid), 16'd0);

    // Back-to-back words on dutA, results on consecutive cycles
    @(negedge clk); applyStimulus(1'b1, 8'hB4, 3'd4, 2'd1);
    @(negedge clk); applyStimulus(1'b1, 8'hB4, 3'd2, 2'd2);
    @(negedge clk); applyStimulus(1'b1, 8'hB4, 3'd3, 2'd3);
    @(negedge clk); a.iValid = 1'b0; #1;
    checkOutput("b2b_v0", 16'(a.oValid), 16'd1);
    checkOutput("b2b_lsr4", 16'(a.oBits), 16'h000B);
    @(negedge clk); #1;
    checkOutput("b2b_v1", 16'(a.oValid), 16'd1);
    checkOutput("b2b_asr2", 16'(a.oBits), 16'h00ED);
    @(negedge clk); #1;
    checkOutput("b2b_v2", 16'(a.oValid), 16'd1);
    checkOutput("b2b_mode3", 16'(a.oBits), ROT ? 16'h00A5 : 16'h00A0);
    @(negedge clk); #1;
    checkOutput("b2b_drained", 16'(a.oValid), 16'd0);

    // width 6, amount 7 >= width, dutB
    @(negedge clk); b.iValid = 1'b1; b.iBits = 6'h01; b.iShift = 3'd7; b.iMode = 2'd0;
    @(negedge clk); b.iBits = 6'h20; b.iMode = 2'd2;
    @(negedge clk); b.iBits = 6'h01; b.iMode = 2'd3; #1;
    checkOutput("w6_v0", 16'(b.oValid), 16'd1);
    checkOutput("w6_lsl7", 16'(b.oBits), 16'h0000);
    @(negedge clk); b.iValid = 1'b0; #1;
    checkOutput("w6_v1", 16'(b.oValid), 16'd1);
    checkOutput("w6_asr7", 16'(b.oBits), 16'h003F);
    @(negedge clk); #1;
    checkOutput("w6_v2", 16'(b.oValid), 16'd1);
    checkOutput("w6_mode3_7", 16'(b.oBits), ROT ? 16'h0002 : 16'h0000);

    // Single-stage latency on dutC
    @(negedge clk); c.iValid = 1'b1; c.iBits = 8'hB4; c.iShift = 3'd5; c.iMode = 2'd2;
    @(negedge clk); c.iValid = 1'b0; #1;
    checkOutput("s1_ovalid", 16'(c.oValid), 16'd1);
    checkOutput("s1_asr5", 16'(c.oBits), 16'h00FD);

    // Backpressure on dutA: oReady low for 6 cycles, 5 words offered
    @(negedge clk);
    a.oReady = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      applyStimulus(1'b1, bp[acc], 3'd1, 2'd0);
      #1;
      if (cyc >= 3) begin
        checkOutput("bp_iready_low", 16'(a.iReady), 16'd0);
        checkOutput("bp_hold_valid", 16'(a.oValid), 16'd1);
        checkOutput("bp_hold_bits", 16'(a.oBits), 16'(bpExp[0]));
      end
      if (a.iReady) acc++;
    end
    checkOutput("bp_accepts", 16'(acc), 16'd3);
    got = 0;
    for (int cyc = 0; cyc < 20 && (got < 5 || acc < 5); cyc++) begin
      @(negedge clk);
      a.oReady = 1'b1;
      if (acc < 5) applyStimulus(1'b1, bp[acc], 3'd1, 2'd0);
      else a.iValid = 1'b0;
      #1;
      if (a.oValid) begin
        checkOutput("bp_order", 16'(a.oBits), (got < 5) ? 16'(bpExp[got]) : 16'hFFFF);
        got++;
      end
      if (a.iValid && a.iReady) acc++;
    end
    a.iValid = 1'b0;
    checkOutput("bp_count", 16'(got), 16'd5);

    // Reset with three words in flight on dutA
    @(negedge clk);
    a.oReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 8'(i + 1), 3'd1, 2'd0);
    end
    @(negedge clk);
    a.iValid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("mid_full", 16'(a.oValid), 16'd1);
    checkOutput("mid_rst_iready", 16'(a.iReady), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    a.oReady = 1'b1;
    #1;
    checkOutput("mid_ovalid", 16'(a.oValid), 16'd0);
    checkOutput("mid_obits", 16'(a.oBits), 16'd0);
    checkOutput("mid_iready", 16'(a.iReady), 16'd1);
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (a.oValid) stale++;
    end
    checkOutput("mid_no_stale", 16'(stale), 16'd0);

    // Random traffic with random backpressure on all three configurations
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      a.iValid = 1'($urandom); a.iBits = 8'($urandom); a.iShift = 3'($urandom);
      a.iMode  = 2'($urandom); a.oReady = ($urandom_range(0, 3) != 0);
      b.iValid = 1'($urandom); b.iBits = 6'($urandom); b.iShift = 3'($urandom);
      b.iMode  = 2'($urandom); b.oReady = ($urandom_range(0, 3) != 0);
      c.iValid = 1'($urandom); c.iBits = 8'($urandom); c.iShift = 3'($urandom);
      c.iMode  = 2'($urandom); c.oReady = ($urandom_range(0, 3) != 0);
      #1;
      monitorCycle();
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      a.iValid = 1'b0; a.oReady = 1'b1;
      b.iValid = 1'b0; b.oReady = 1'b1;
      c.iValid = 1'b0; c.oReady = 1'b1;
      #1;
      monitorCycle();
    end
    checkOutput("rnd_s3_left", 16'(qa.size()), 16'd0);
    checkOutput("rnd_s2_left", 16'(qb.size()), 16'd0);
    checkOutput("rnd_s1_left", 16'(qc.size()), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
